icache_ctrl_fsm: RTL and testbench
==================================

# icache_ctrl_fsm

Parametrised control FSM for the instruction cache, between the fetch stage and the instruction-memory read port. It covers:
- hit/miss decisions, including fetches that straddle two cache lines;
- multi-beat line refills over a request/grant/valid memory handshake;
- bus-error reporting;
- full-cache invalidation sweeps for fence.i.

It drives the icache tag/valid/data array write controls and the pipeline stall.

## Interface
Parameters:
- LINE_BYTES, 16, bytes per cache line; power of two, ≥8
- BUS_BYTES, 4, bytes per memory read beat; power of two, ≤ LINE_BYTES
- INSTR_BYTES, 4, fetch width in bytes
- SETS, 64, number of cache sets; power of two

Derived: BEATS = LINE_BYTES/BUS_BYTES; OFF_W = log2(LINE_BYTES); BEAT_W = max(1, log2(BEATS)); IDX_W = log2(SETS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fetch_en  in  1  fetch request valid this cycle
- hit  in  1  tag hit, line containing the PC
- hit_hi  in  1  tag hit, following line
- block_offset  in  OFF_W  PC byte offset in line
- flush_req  in  1  single-cycle invalidate-all request
- mem_gnt  in  1  memory accepted the line request
- mem_rvalid  in  1  read beat valid
- mem_rerr  in  1  beat carries bus error; qualified by mem_rvalid
- mem_req  out  1  line read request, held until granted
- addr_sel  out  1  0 = PC line, 1 = following line; drives the memory address and the array write index
- cache_wren  out  1  write current beat into the data array
- beat_idx  out  BEAT_W  word slot for cache_wren
- set_valid  out  1  set valid bit, PC line
- replace_tag  out  1  write tag, PC line
- set_valid_hi  out  1  set valid bit, following line
- replace_tag_hi  out  1  write tag, following line
- inval_en  out  1  clear valid bit at inval_idx
- inval_idx  out  IDX_W  set being invalidated
- stall  out  1  freeze PC and fetch pipeline registers
- fetch_fault  out  1  one-cycle pulse, refill ended in bus error
- flush_done  out  1  one-cycle pulse, sweep complete

## Operation
- States: IDLE, REQ_LO, DATA_LO, REQ_HI, DATA_HI, RESUME, FLUSH. Outputs are Mealy-decoded from state and inputs. beat_cnt, inval_idx, the straddle/err flags and the flush_pend flag are registers.
- straddle = (block_offset > LINE_BYTES − INSTR_BYTES).
- IDLE, fetch_en=0: all outputs 0.
- IDLE, fetch_en=1:
  - !hit → REQ_LO, stall=1; latch straddle.
  - hit & (!straddle | hit_hi) → stay IDLE, stall=0.
  - hit & straddle & !hit_hi → REQ_HI, stall=1.
- REQ_LO / REQ_HI: mem_req=1, stall=1; addr_sel=0 in REQ_LO, 1 in REQ_HI. When mem_gnt=1, go to DATA_LO / DATA_HI and clear beat_cnt. mem_req never drops before grant.
- DATA_LO / DATA_HI, each mem_rvalid beat:
  - cache_wren=1, beat_idx=beat_cnt, addr_sel as in the matching REQ state; beat_cnt increments.
  - A beat with mem_rerr sets the sticky err flag.
  - Last beat (beat_cnt=BEATS−1), err clear: DATA_LO asserts set_valid+replace_tag; DATA_HI asserts set_valid_hi+replace_tag_hi.
  - Last beat, err set (including this beat): no valid/tag write, fetch_fault=1.
  - After the last beat, DATA_LO goes to REQ_HI if latched straddle & !hit_hi & !err; every other case goes to RESUME.
- RESUME: stall=1 for one cycle (array re-lookup), clear err → IDLE.
- Flush:
  - flush_req in IDLE → FLUSH.
  - flush_req in any other state sets flush_pend; the pending flush is taken from RESUME instead of IDLE. Refill bursts are never aborted.
  - FLUSH: stall=1, inval_en=1, inval_idx increments each cycle from 0. At SETS−1: flush_done=1 → IDLE.
  - Repeated flush_req while in FLUSH or while pending is absorbed.
- Reset (any state, mid-burst included): state IDLE; beat_cnt, inval_idx, flags = 0. Outputs follow IDLE decode, all 0 with fetch_en=0. Orphaned beats arriving after reset are the memory's responsibility.

## Timing
- Hit: stall=0 in the lookup cycle, zero penalty.
- Single-line miss, grant at first REQ cycle, back-to-back beats: stall high for BEATS+3 cycles (IDLE, REQ_LO, BEATS data cycles, RESUME).
- Straddling double miss: 2·BEATS+4 stalled cycles.
- Gaps in mem_rvalid extend the DATA states cycle-for-cycle, with no timeout.
- Flush: SETS+1 stalled cycles from entry, including the IDLE request cycle.
- beat_cnt wraps to 0 after the last beat; the wrap is unobservable outside the DATA states.

## Structure
- Shared package `icache_pkg`: state enum encoding (3 bits), BEATS/BEAT_W/IDX_W derivation functions, straddle helper function.
- Sub-module `icache_refill_cnt`: beat counter with last-beat flag, parametrised by BEATS. Instantiated once and shared by both DATA states.
- The flush sweep counter stays inline.

## Test plan
- Defaults, hit with offset=4 → stall=0, no mem_req, state stays IDLE.
- Miss, offset=0, gnt after 2 cycles, 4 beats → cache_wren on 4 beats with beat_idx 0..3; set_valid+replace_tag on beat 3; stall high 8 cycles.
- Miss, offset=14, hit_hi=0 → both lines refilled; addr_sel=1 during REQ_HI/DATA_HI; set_valid_hi on the final beat.
- Beat 2 of 4 has mem_rerr → no set_valid, fetch_fault pulse on beat 3, REQ_HI skipped, IDLE after RESUME.
- flush_req during DATA_LO → refill completes, then FLUSH sweeps inval_idx 0..63, flush_done at idx 63.
- rst asserted mid-DATA_HI → all outputs 0 asynchronously; the next miss starts cleanly with beat_idx=0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache control block: state encoding,
// geometry derivation and the line-straddle test.
package icache_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        DATA_LO = 3'd2,
        REQ_HI  = 3'd3,
        DATA_HI = 3'd4,
        RESUME  = 3'd5,
        FLUSH   = 3'd6
    } icache_state_e;

    // Memory beats needed to fill one line.
    function automatic int calc_beats(input int line_bytes, input int bus_bytes);
        return line_bytes / bus_bytes;
    endfunction

    // Beat counter width; never narrower than one bit so a single-beat line still has a port.
    function automatic int calc_beat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Set index width.
    function automatic int calc_idx_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    // A fetch straddles when its last byte falls in the following line.
    function automatic logic is_straddle(input int offset, input int line_bytes,
                                         input int instr_bytes);
        return offset > (line_bytes - instr_bytes);
    endfunction

endpackage

// File: rtl/icache_refill_cnt.sv
// Beat counter shared by both refill data phases. Wraps to zero after the
// last beat and flags that beat combinationally.
module icache_refill_cnt #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [BEAT_W-1:0] cnt_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == BEAT_W'(BEATS - 1));
    assign cnt_o  = cnt_q;

    // Next count: clear wins over increment, increment wraps on the last beat.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = last_o ? '0 : cnt_q + BEAT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/icache_ctrl_fsm.sv
// Instruction-cache control FSM: hit/miss decision (including fetches that
// straddle two lines), multi-beat refills, bus-error reporting and the
// fence.i invalidate-all sweep. Outputs are decoded from state and inputs.
module icache_ctrl_fsm
    import icache_pkg::*;
#(
    parameter int LINE_BYTES  = 16,
    parameter int BUS_BYTES   = 4,
    parameter int INSTR_BYTES = 4,
    parameter int SETS        = 64,
    localparam int BEATS      = calc_beats(LINE_BYTES, BUS_BYTES),
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int BEAT_W     = calc_beat_w(BEATS),
    localparam int IDX_W      = calc_idx_w(SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en_i,
    input  logic              hit_i,
    input  logic              hit_hi_i,
    input  logic [OFF_W-1:0]  block_offset_i,
    input  logic              flush_req_i,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic              mem_rerr_i,
    output logic              mem_req_o,
    output logic              addr_sel_o,
    output logic              cache_wren_o,
    output logic [BEAT_W-1:0] beat_idx_o,
    output logic              set_valid_o,
    output logic              replace_tag_o,
    output logic              set_valid_hi_o,
    output logic              replace_tag_hi_o,
    output logic              inval_en_o,
    output logic [IDX_W-1:0]  inval_idx_o,
    output logic              stall_o,
    output logic              fetch_fault_o,
    output logic              flush_done_o
);

    icache_state_e     state_q, state_d;
    logic              straddle_q, straddle_d;
    logic              err_q, err_d;
    logic              flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]  inval_idx_q, inval_idx_d;

    logic              cnt_clr, cnt_inc, cnt_last;
    logic [BEAT_W-1:0] beat_cnt;
    logic              straddle_now;
    logic              err_now;

    assign straddle_now = is_straddle(32'(block_offset_i), LINE_BYTES, INSTR_BYTES);
    // Error status including a faulting beat arriving this cycle.
    assign err_now      = err_q | (mem_rvalid_i & mem_rerr_i);
    assign inval_idx_o  = inval_idx_q;

    icache_refill_cnt #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_refill_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (beat_cnt),
        .last_o (cnt_last)
    );

    // Next-state and Mealy output decode.
    always_comb begin
        state_d          = state_q;
        straddle_d       = straddle_q;
        err_d            = err_q;
        flush_pend_d     = flush_pend_q;
        inval_idx_d      = inval_idx_q;
        cnt_clr          = 1'b0;
        cnt_inc          = 1'b0;
        mem_req_o        = 1'b0;
        addr_sel_o       = 1'b0;
        cache_wren_o     = 1'b0;
        beat_idx_o       = '0;
        set_valid_o      = 1'b0;
        replace_tag_o    = 1'b0;
        set_valid_hi_o   = 1'b0;
        replace_tag_hi_o = 1'b0;
        inval_en_o       = 1'b0;
        stall_o          = 1'b0;
        fetch_fault_o    = 1'b0;
        flush_done_o     = 1'b0;

        // Refill bursts are never aborted: a flush arriving mid-refill waits for RESUME.
        if (flush_req_i && state_q != IDLE && state_q != FLUSH)
            flush_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    stall_o = 1'b1;
                    state_d = FLUSH;
                end else if (fetch_en_i) begin
                    straddle_d = straddle_now;
                    if (!hit_i) begin
                        stall_o = 1'b1;
                        state_d = REQ_LO;
                    end else if (straddle_now && !hit_hi_i) begin
                        stall_o = 1'b1;
                        state_d = REQ_HI;
                    end
                end
            end

            REQ_LO, REQ_HI: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                addr_sel_o = (state_q == REQ_HI);
                if (mem_gnt_i) begin
                    cnt_clr = 1'b1;
                    state_d = (state_q == REQ_HI) ? DATA_HI : DATA_LO;
                end
            end

            DATA_LO, DATA_HI: begin
                stall_o    = 1'b1;
                addr_sel_o = (state_q == DATA_HI);
                if (mem_rvalid_i) begin
                    cache_wren_o = 1'b1;
                    beat_idx_o   = beat_cnt;
                    cnt_inc      = 1'b1;
                    if (mem_rerr_i)
                        err_d = 1'b1;
                    if (cnt_last) begin
                        if (err_now) begin
                            fetch_fault_o = 1'b1;
                        end else if (state_q == DATA_LO) begin
                            set_valid_o   = 1'b1;
                            replace_tag_o = 1'b1;
                        end else begin
                            set_valid_hi_o   = 1'b1;
                            replace_tag_hi_o = 1'b1;
                        end
                        // Second line is only fetched when the first one arrived intact.
                        if (state_q == DATA_LO && straddle_q && !hit_hi_i && !err_now)
                            state_d = REQ_HI;
                        else
                            state_d = RESUME;
                    end
                end
            end

            RESUME: begin
                stall_o = 1'b1;
                err_d   = 1'b0;
                if (flush_pend_q || flush_req_i) begin
                    flush_pend_d = 1'b0;
                    state_d      = FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end

            FLUSH: begin
                stall_o     = 1'b1;
                inval_en_o  = 1'b1;
                inval_idx_d = inval_idx_q + IDX_W'(1);
                if (inval_idx_q == IDX_W'(SETS - 1)) begin
                    flush_done_o = 1'b1;
                    inval_idx_d  = '0;
                    state_d      = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            straddle_q   <= 1'b0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            inval_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            straddle_q   <= straddle_d;
            err_q        <= err_d;
            flush_pend_q <= flush_pend_d;
            inval_idx_q  <= inval_idx_d;
        end
    end

endmodule

// File: tb/tb_icache_ctrl_fsm.sv
// Scoreboard bench for icache_ctrl_fsm (default geometry: 4 beats, 64 sets).
// Stimulus pushes expected array-write / flush events; a negedge monitor pops
// and compares whenever the DUT shows one.
module tb_icache_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_en, hit, hit_hi, flush_req, mem_gnt, mem_rvalid, mem_rerr;
    logic [3:0] block_offset;
    logic       mem_req, addr_sel, cache_wren, set_valid, replace_tag;
    logic       set_valid_hi, replace_tag_hi, inval_en, stall, fetch_fault, flush_done;
    logic [1:0] beat_idx;
    logic [5:0] inval_idx;

    int total = 0;
    int bad   = 0;
    int stall_total = 0;
    logic [16:0] expq[$];

    always #5 clk = ~clk;

    icache_ctrl_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en_i       (fetch_en),
        .hit_i            (hit),
        .hit_hi_i         (hit_hi),
        .block_offset_i   (block_offset),
        .flush_req_i      (flush_req),
        .mem_gnt_i        (mem_gnt),
        .mem_rvalid_i     (mem_rvalid),
        .mem_rerr_i       (mem_rerr),
        .mem_req_o        (mem_req),
        .addr_sel_o       (addr_sel),
        .cache_wren_o     (cache_wren),
        .beat_idx_o       (beat_idx),
        .set_valid_o      (set_valid),
        .replace_tag_o    (replace_tag),
        .set_valid_hi_o   (set_valid_hi),
        .replace_tag_hi_o (replace_tag_hi),
        .inval_en_o       (inval_en),
        .inval_idx_o      (inval_idx),
        .stall_o          (stall),
        .fetch_fault_o    (fetch_fault),
        .flush_done_o     (flush_done)
    );

    // Event word: {wren, beat_idx, addr_sel, sv, rt, sv_hi, rt_hi, fault, inval_en, inval_idx, done}
    function automatic logic [16:0] mk(bit w, int b, bit a, bit sv, bit rt, bit svh, bit rth,
                                       bit f, bit ie, int ii, bit d);
        return {w, 2'(b), a, sv, rt, svh, rth, f, ie, 6'(ii), d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: count stalls, pop/compare on every visible array-write or flush event.
    initial begin
        forever begin
            @(negedge clk);
            if (stall === 1'b1) stall_total++;
            if (cache_wren | set_valid | replace_tag | set_valid_hi | replace_tag_hi |
                fetch_fault | inval_en | flush_done) begin
                logic [16:0] act;
                act = {cache_wren, beat_idx, addr_sel, set_valid, replace_tag, set_valid_hi,
                       replace_tag_hi, fetch_fault, inval_en, inval_idx, flush_done};
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got %0h expected none", act);
                end else begin
                    chk("event", 32'(act), 32'(expq.pop_front()));
                end
            end
        end
    end

    // Drive one refill from its REQ state through the last beat; ends in the following state.
    task automatic refill(input bit hi, input int gnt_wait, input int err_beat,
                          input int gap_beat, input int flush_beat);
        bit err;
        for (int i = 0; i < gnt_wait; i++) begin
            mem_gnt = 1'b0;
            @(negedge clk);
            chk(hi ? "req_hi_wait" : "req_lo_wait", 32'({mem_req, addr_sel}), 32'({1'b1, hi}));
            step();
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        chk(hi ? "req_hi_gnt" : "req_lo_gnt", 32'({mem_req, addr_sel}), 32'({1'b1, hi}));
        step();
        mem_gnt = 1'b0;
        err = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == gap_beat) begin
                mem_rvalid = 1'b0;
                step();
            end
            mem_rvalid = 1'b1;
            mem_rerr   = (b == err_beat);
            flush_req  = (b == flush_beat);
            err        = err | (b == err_beat);
            expq.push_back(mk(1, b, hi, b == 3 && !err && !hi, b == 3 && !err && !hi,
                              b == 3 && !err && hi, b == 3 && !err && hi, b == 3 && err,
                              0, 0, 0));
            step();
        end
        mem_rvalid = 1'b0;
        mem_rerr   = 1'b0;
        flush_req  = 1'b0;
    endtask

    task automatic start_miss(input int off, input bit hh);
        fetch_en = 1'b1; hit = 1'b0; hit_hi = hh; block_offset = 4'(off);
        @(negedge clk);
        chk("miss_lookup_stall", 32'({stall, mem_req}), 32'b10);
        step();
        fetch_en = 1'b0;
    endtask

    initial begin
        int snap;
        rst = 1'b1; fetch_en = 0; hit = 0; hit_hi = 0; block_offset = '0; flush_req = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rerr = 0;
        #2;
        chk("reset_outputs", 32'({mem_req, addr_sel, cache_wren, beat_idx, set_valid, replace_tag,
             set_valid_hi, replace_tag_hi, inval_en, inval_idx, stall, fetch_fault, flush_done}), 0);
        step(); step();
        rst = 1'b0;

        // Hit at offset 4: no penalty, no request.
        fetch_en = 1; hit = 1; block_offset = 4'd4;
        @(negedge clk);
        chk("hit_stall", 32'({stall, mem_req}), 0);
        step();
        fetch_en = 0;
        @(negedge clk);
        chk("hit_stays_idle", 32'({stall, mem_req}), 0);
        step();

        // Single-line miss, grant on second REQ cycle: 8 stalled cycles.
        snap = stall_total;
        start_miss(0, 0);
        refill(0, 1, -1, -1, -1);
        step();                           // RESUME
        @(negedge clk);
        chk("miss_stall_cycles", 32'(stall_total - snap), 8);
        chk("miss_back_idle", 32'({stall, mem_req}), 0);
        step();

        // Straddling double miss at offset 14: 2*4+4 = 12 stalled cycles.
        snap = stall_total;
        start_miss(14, 0);
        refill(0, 0, -1, -1, -1);
        refill(1, 0, -1, -1, -1);
        step();
        @(negedge clk);
        chk("straddle_stall_cycles", 32'(stall_total - snap), 12);
        chk("straddle_back_idle", 32'({stall, mem_req}), 0);
        step();

        // Bus error on beat 2 (with a gap before beat 1): fault on beat 3, REQ_HI skipped.
        snap = stall_total;
        start_miss(14, 0);
        refill(0, 0, 2, 1, -1);
        @(negedge clk);
        chk("err_resume", 32'({stall, mem_req}), 32'b10);
        step();
        @(negedge clk);
        chk("err_idle_no_req_hi", 32'({stall, mem_req}), 0);
        chk("err_stall_cycles", 32'(stall_total - snap), 8);
        step();

        // Flush requested mid DATA_LO: refill completes, then sweep from RESUME.
        snap = stall_total;
        start_miss(0, 0);
        refill(0, 0, -1, -1, 1);
        for (int i = 0; i < 64; i++) expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, i, i == 63));
        step();                           // RESUME
        for (int i = 0; i < 64; i++) begin
            flush_req = (i == 10);        // repeated request inside the sweep is absorbed
            step();
        end
        flush_req = 0;
        @(negedge clk);
        chk("pend_flush_idle", 32'({stall, inval_en}), 0);
        chk("pend_flush_stall_cycles", 32'(stall_total - snap), 1 + 1 + 4 + 1 + 64);
        step();

        // Flush from IDLE: SETS+1 stalled cycles.
        snap = stall_total;
        flush_req = 1;
        for (int i = 0; i < 64; i++) expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, i, i == 63));
        step();
        flush_req = 0;
        repeat (64) step();
        @(negedge clk);
        chk("idle_flush_stall_cycles", 32'(stall_total - snap), 65);
        step();

        // Reset in the middle of DATA_HI, with orphan beats still arriving.
        start_miss(14, 0);
        refill(0, 0, -1, -1, -1);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1;
            expq.push_back(mk(1, b, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            step();
        end
        rst = 1;
        #1;
        chk("async_reset_outputs", 32'({mem_req, addr_sel, cache_wren, beat_idx, set_valid,
             replace_tag, set_valid_hi, replace_tag_hi, inval_en, inval_idx, stall, fetch_fault,
             flush_done}), 0);
        step();
        rst = 0;
        mem_rvalid = 0;
        snap = stall_total;
        start_miss(0, 0);
        refill(0, 0, -1, -1, -1);
        step();
        @(negedge clk);
        chk("post_reset_stall_cycles", 32'(stall_total - snap), 7);
        chk("post_reset_idle", 32'({stall, mem_req}), 0);
        step();

        chk("scoreboard_drained", 32'(expq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
